// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences the PC register, runs a single-outstanding
// imem request/ack handshake and holds the fetched word in a one-entry output slot.
module fetch_ctrl #(
    parameter int            N        = 32,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] pc,
    output logic         n_EN,
    output logic [N-1:0] pc_next,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic         instr_valid,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc
);

    typedef enum logic [1:0] {BOOT, RUN, WAIT, DROP} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] hold_addr;
    logic [N-1:0] pc_inc;
    logic         slot_free;
    logic         consume;
    logic         capture;
    logic         squash;
    logic         load_hold;

    assign pc_inc    = pc + N'(4);
    assign slot_free = ~instr_valid | ~stall;
    assign consume   = instr_valid & ~stall;

    // PC sequencing and the memory handshake are combinational so a redirect or ack
    // reaches the PC register in the same cycle it arrives.
    always_comb begin
        n_EN      = 1'b1;
        pc_next   = pc_inc;
        imem_req  = 1'b0;
        imem_addr = pc;
        capture   = 1'b0;
        squash    = 1'b0;
        load_hold = 1'b0;
        state_nxt = state;
        if (!RST) begin
            case (state)
                BOOT: begin
                    n_EN      = 1'b0;
                    pc_next   = RESET_PC;
                    state_nxt = RUN;
                end
                RUN: begin
                    imem_req = slot_free & ~redirect_valid;
                    if (redirect_valid) begin
                        n_EN    = 1'b0;
                        pc_next = redirect_pc;
                        squash  = 1'b1;
                    end else if (imem_req && imem_ack) begin
                        capture = 1'b1;
                        n_EN    = 1'b0;
                    end else if (imem_req) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    imem_req = 1'b1;
                    if (redirect_valid) begin
                        n_EN    = 1'b0;
                        pc_next = redirect_pc;
                        if (imem_ack) begin
                            state_nxt = RUN;
                        end else begin
                            load_hold = 1'b1;
                            state_nxt = DROP;
                        end
                    end else if (imem_ack) begin
                        capture   = 1'b1;
                        n_EN      = 1'b0;
                        state_nxt = RUN;
                    end
                end
                DROP: begin
                    // The abandoned request must complete at its original address.
                    imem_req  = 1'b1;
                    imem_addr = hold_addr;
                    if (redirect_valid) begin
                        n_EN    = 1'b0;
                        pc_next = redirect_pc;
                    end
                    if (imem_ack) state_nxt = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= BOOT;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            hold_addr   <= '0;
        end else begin
            state <= state_nxt;
            if (load_hold) hold_addr <= pc;
            if (capture) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= pc;
            end else if (squash || consume) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the PC register and a memory returning addr^0xA5A5A5A5.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] pc = 32'h0;
    logic        n_EN;
    logic [31:0] pc_next;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int cmp = 0;
    int err = 0;

    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    fetch_ctrl #(.N(32), .RESET_PC(32'h400)) dut (
        .CLK(CLK), .RST(RST), .pc(pc), .n_EN(n_EN), .pc_next(pc_next),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (n_EN == 1'b0) pc <= pc_next;

    assign imem_rdata = imem_addr ^ PAT;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reset, pass the BOOT cycle, return in the first RUN cycle with pc=0x400.
    task automatic do_reset();
        RST = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
        step(); step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b1;
        step(); step();
        #1;
        cmp++; if (instr_valid !== 1'b0) begin err++; $display("FAIL rst_valid: got %h want 0", instr_valid); end
        cmp++; if (instr !== 32'h0) begin err++; $display("FAIL rst_instr: got %h want 0", instr); end
        cmp++; if (instr_pc !== 32'h0) begin err++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        cmp++; if (n_EN !== 1'b1) begin err++; $display("FAIL rst_nen: got %h want 1", n_EN); end
        cmp++; if (imem_req !== 1'b0) begin err++; $display("FAIL rst_req: got %h want 0", imem_req); end
        cmp++; if (pc_next !== pc + 32'd4) begin err++; $display("FAIL rst_pc_next: got %h want %h", pc_next, pc + 32'd4); end
        cmp++; if (imem_addr !== pc) begin err++; $display("FAIL rst_addr: got %h want %h", imem_addr, pc); end
        RST = 1'b0; imem_ack = 1'b0;
        #1;
        cmp++; if (n_EN !== 1'b0) begin err++; $display("FAIL boot_nen: got %h want 0", n_EN); end
        cmp++; if (pc_next !== 32'h400) begin err++; $display("FAIL boot_pc_next: got %h want 00000400", pc_next); end
        cmp++; if (imem_req !== 1'b0) begin err++; $display("FAIL boot_req: got %h want 0", imem_req); end
        step();
        cmp++; if (imem_req !== 1'b1) begin err++; $display("FAIL first_req: got %h want 1", imem_req); end
        cmp++; if (imem_addr !== 32'h400) begin err++; $display("FAIL first_addr: got %h want 00000400", imem_addr); end
    endtask

    task automatic test_streaming();
        do_reset();
        imem_ack = 1'b1;
        #1;
        cmp++; if (n_EN !== 1'b0) begin err++; $display("FAIL stream_nen: got %h want 0", n_EN); end
        cmp++; if (pc_next !== 32'h404) begin err++; $display("FAIL stream_pc_next: got %h want 00000404", pc_next); end
        for (int k = 0; k < 3; k++) begin
            step();
            cmp++; if (instr_valid !== 1'b1) begin err++; $display("FAIL stream_valid[%0d]: got %h want 1", k, instr_valid); end
            cmp++; if (instr_pc !== 32'h400 + 32'(4 * k)) begin err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, instr_pc, 32'h400 + 32'(4 * k)); end
            cmp++; if (instr !== ((32'h400 + 32'(4 * k)) ^ PAT)) begin err++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instr, (32'h400 + 32'(4 * k)) ^ PAT); end
            cmp++; if (imem_addr !== 32'h404 + 32'(4 * k)) begin err++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr, 32'h404 + 32'(4 * k)); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 3);
            #1;
            cmp++; if (imem_req !== 1'b1) begin err++; $display("FAIL wait_req[%0d]: got %h want 1", i, imem_req); end
            cmp++; if (imem_addr !== 32'h400) begin err++; $display("FAIL wait_addr[%0d]: got %h want 00000400", i, imem_addr); end
            cmp++; if (n_EN !== (i != 3)) begin err++; $display("FAIL wait_nen[%0d]: got %h want %h", i, n_EN, (i != 3)); end
            cmp++; if (instr_valid !== 1'b0) begin err++; $display("FAIL wait_valid[%0d]: got %h want 0", i, instr_valid); end
            step();
        end
        imem_ack = 1'b0;
        #1;
        cmp++; if (instr_valid !== 1'b1) begin err++; $display("FAIL wait_cap_valid: got %h want 1", instr_valid); end
        cmp++; if (instr_pc !== 32'h400) begin err++; $display("FAIL wait_cap_pc: got %h want 00000400", instr_pc); end
        cmp++; if (instr !== (32'h400 ^ PAT)) begin err++; $display("FAIL wait_cap_instr: got %h want %h", instr, 32'h400 ^ PAT); end
        cmp++; if (imem_addr !== 32'h404) begin err++; $display("FAIL wait_next_addr: got %h want 00000404", imem_addr); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        imem_ack = 1'b1;
        step(); step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            cmp++; if (imem_req !== 1'b0) begin err++; $display("FAIL bp_req[%0d]: got %h want 0", i, imem_req); end
            cmp++; if (n_EN !== 1'b1) begin err++; $display("FAIL bp_nen[%0d]: got %h want 1", i, n_EN); end
            cmp++; if (instr_valid !== 1'b1) begin err++; $display("FAIL bp_valid[%0d]: got %h want 1", i, instr_valid); end
            cmp++; if (instr_pc !== 32'h404) begin err++; $display("FAIL bp_pc[%0d]: got %h want 00000404", i, instr_pc); end
            cmp++; if (instr !== (32'h404 ^ PAT)) begin err++; $display("FAIL bp_instr[%0d]: got %h want %h", i, instr, 32'h404 ^ PAT); end
            step();
        end
        stall = 1'b0;
        #1;
        cmp++; if (imem_req !== 1'b1) begin err++; $display("FAIL bp_resume_req: got %h want 1", imem_req); end
        cmp++; if (imem_addr !== 32'h408) begin err++; $display("FAIL bp_resume_addr: got %h want 00000408", imem_addr); end
        cmp++; if (n_EN !== 1'b0) begin err++; $display("FAIL bp_resume_nen: got %h want 0", n_EN); end
        step();
        cmp++; if (instr_pc !== 32'h408) begin err++; $display("FAIL bp_after_pc: got %h want 00000408", instr_pc); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_ack = 1'b1;
        step(); step();
        imem_ack = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h800;
        #1;
        cmp++; if (instr_valid !== 1'b0) begin err++; $display("FAIL rw_slot_empty: got %h want 0", instr_valid); end
        cmp++; if (imem_addr !== 32'h408) begin err++; $display("FAIL rw_wait_addr: got %h want 00000408", imem_addr); end
        cmp++; if (n_EN !== 1'b0) begin err++; $display("FAIL rw_nen: got %h want 0", n_EN); end
        cmp++; if (pc_next !== 32'h800) begin err++; $display("FAIL rw_pc_next: got %h want 00000800", pc_next); end
        step();
        redirect_valid = 1'b0;
        #1;
        cmp++; if (pc !== 32'h800) begin err++; $display("FAIL rw_pc: got %h want 00000800", pc); end
        cmp++; if (imem_req !== 1'b1) begin err++; $display("FAIL rw_drop_req: got %h want 1", imem_req); end
        cmp++; if (imem_addr !== 32'h408) begin err++; $display("FAIL rw_drop_addr: got %h want 00000408", imem_addr); end
        cmp++; if (n_EN !== 1'b1) begin err++; $display("FAIL rw_drop_nen: got %h want 1", n_EN); end
        step();
        imem_ack = 1'b1;
        #1;
        cmp++; if (imem_addr !== 32'h408) begin err++; $display("FAIL rw_drop_ack_addr: got %h want 00000408", imem_addr); end
        cmp++; if (n_EN !== 1'b1) begin err++; $display("FAIL rw_drop_ack_nen: got %h want 1", n_EN); end
        step();
        imem_ack = 1'b0;
        #1;
        cmp++; if (instr_valid !== 1'b0) begin err++; $display("FAIL rw_discard: got %h want 0", instr_valid); end
        cmp++; if (imem_req !== 1'b1) begin err++; $display("FAIL rw_new_req: got %h want 1", imem_req); end
        cmp++; if (imem_addr !== 32'h800) begin err++; $display("FAIL rw_new_addr: got %h want 00000800", imem_addr); end
    endtask

    task automatic test_wrap_simultaneous();
        do_reset();
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
        #1;
        cmp++; if (imem_req !== 1'b0) begin err++; $display("FAIL sim_req: got %h want 0", imem_req); end
        cmp++; if (n_EN !== 1'b0) begin err++; $display("FAIL sim_nen: got %h want 0", n_EN); end
        cmp++; if (pc_next !== 32'hFFFFFFFC) begin err++; $display("FAIL sim_pc_next: got %h want fffffffc", pc_next); end
        step();
        redirect_valid = 1'b0;
        #1;
        cmp++; if (instr_valid !== 1'b0) begin err++; $display("FAIL sim_no_capture: got %h want 0", instr_valid); end
        cmp++; if (imem_addr !== 32'hFFFFFFFC) begin err++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        cmp++; if (pc_next !== 32'h0) begin err++; $display("FAIL wrap_pc_next: got %h want 00000000", pc_next); end
        step();
        cmp++; if (instr_pc !== 32'hFFFFFFFC) begin err++; $display("FAIL wrap_instr_pc: got %h want fffffffc", instr_pc); end
        cmp++; if (imem_addr !== 32'h0) begin err++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_addr); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        cmp++; if (imem_req !== 1'b0) begin err++; $display("FAIL squash_req: got %h want 0", imem_req); end
        step();
        stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
        #1;
        cmp++; if (instr_valid !== 1'b0) begin err++; $display("FAIL squash_valid: got %h want 0", instr_valid); end
        cmp++; if (imem_addr !== 32'h100) begin err++; $display("FAIL squash_addr: got %h want 00000100", imem_addr); end
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
        test_reset();
        test_streaming();
        test_wait_states();
        test_back_pressure();
        test_redirect_wait();
        test_wrap_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the IF stage of the pipelined MIPS core. It sequences the program counter register by driving its active-low load enable and next value, and runs a single-outstanding request/acknowledge handshake with instruction memory. Fetched words are held in a one-entry output slot feeding the IF/ID register. The block honours back-pressure from the hazard unit and applies branch/jump redirects, discarding any in-flight wrong-path fetch.

## Interface
- N, 32, PC / address width.
- RESET_PC, 0, PC value loaded after reset.
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- pc  in  N  current value from the PC register. Reflects pc_next one cycle after n_EN=0.
- n_EN  out  N/A (1)  PC register load enable, active low.
- pc_next  out  N  value to load into the PC register.
- stall  in  1  IF/ID hold from the hazard unit. Slot not consumed while 1.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  N  redirect target.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  N  request address.
- imem_ack  in  1  data valid on imem_rdata. Only meaningful while imem_req=1.
- imem_rdata  in  32  fetched instruction.
- instr_valid  out  1  output slot holds a valid instruction.
- instr  out  32  slot instruction.
- instr_pc  out  N  address of slot instruction.

## Operation
- State registers:
  - FSM states: BOOT, RUN, WAIT, DROP.
  - Output slot: instr_valid, instr, instr_pc.
  - hold_addr: N bits.
- Defaults in every state: n_EN=1, pc_next=pc+4 (mod 2^N), imem_req=0, imem_addr=pc.
- Slot status:
  - slot_free = ~instr_valid | ~stall.
  - The slot is consumed in any cycle with instr_valid=1 and stall=0. On consumption, instr_valid clears unless a new capture occurs in the same cycle.
- BOOT:
  - Drives n_EN=0, pc_next=RESET_PC.
  - redirect_valid is ignored.
  - Next state is RUN.
- RUN:
  - imem_req = slot_free & ~redirect_valid.
  - If redirect_valid: n_EN=0, pc_next=redirect_pc, instr_valid cleared (squash). Stay in RUN.
  - Else if imem_req & imem_ack: capture (instr←imem_rdata, instr_pc←pc, instr_valid←1), n_EN=0, pc_next=pc+4. Stay in RUN.
  - Else if imem_req & ~imem_ack: go to WAIT.
- WAIT:
  - imem_req=1, imem_addr=pc.
  - The slot is guaranteed empty here.
  - ack & ~redirect: capture, n_EN=0, pc_next=pc+4, go to RUN.
  - ack & redirect: discard data, n_EN=0, pc_next=redirect_pc, go to RUN.
  - ~ack & redirect: hold_addr←pc, n_EN=0, pc_next=redirect_pc, go to DROP.
  - ~ack & ~redirect: stay in WAIT.
- DROP:
  - imem_req=1, imem_addr=hold_addr.
  - On ack: discard data, go to RUN.
  - Any redirect_valid: n_EN=0, pc_next=redirect_pc. hold_addr is unchanged. The state follows ack as above.
- Handshake rules:
  - Once imem_req rises, it stays 1 with a constant imem_addr until the cycle imem_ack=1.
  - At most one request is outstanding.
  - imem_ack while imem_req=0 is ignored.
- Priority: RST > redirect_valid > imem_ack capture.
- stall has no effect in WAIT or DROP.

## Timing
- Under RST=1:
  - Next state is BOOT.
  - instr_valid=0, instr=0, instr_pc=0, hold_addr=0.
  - Combinational outputs while RST=1: n_EN=1, imem_req=0, pc_next=pc+4, imem_addr=pc.
- Reset mid-request: the outstanding request is abandoned. Instruction memory is reset by the same RST.
- First request: the cycle after BOOT, at imem_addr=RESET_PC.
- Latency:
  - Zero-wait memory: imem_ack→instr_valid is 1 cycle, sustained throughput 1 instruction/cycle.
  - Each wait cycle adds 1 cycle.
- Redirect:
  - pc equals redirect_pc the next cycle.
  - The first request to the target is issued the next cycle in RUN, or after the DROP ack.
- Wrap-around: pc_next = pc+4 truncated to N bits, so 0xFFFFFFFC→0x00000000.

## Test plan
- Boot: RST=1 for 2 cycles, RESET_PC=0x400, then RST=0 -> BOOT cycle shows n_EN=0, pc_next=0x400. Next cycle shows imem_req=1, imem_addr=0x400.
- Streaming: imem_ack=1 every cycle, stall=0, rdata=addr^0xA5A5A5A5 -> instr_pc 0x400, 0x404, 0x408 on consecutive cycles, instr_valid continuously 1.
- Wait states: ack 3 cycles after request -> imem_req and imem_addr=0x400 stable for all 4 cycles, n_EN=1 until the ack cycle, instr_valid 1 the cycle after.
- Back-pressure: slot valid with instr_pc=0x404, stall=1 for 4 cycles -> imem_req=0, instr/instr_pc unchanged. Requests resume the cycle stall drops.
- Redirect in WAIT: request to 0x408 pending, redirect_valid=1 with redirect_pc=0x800 -> DROP with imem_addr held at 0x408, ack data discarded (instr_valid stays 0). Next request imem_addr=0x800.
- Wrap and simultaneous events: pc=0xFFFFFFFC with ack -> pc_next=0x00000000. Redirect and ack in the same RUN cycle -> no capture, imem_req=0, pc_next=redirect_pc.
